prco_fetch: RTL and testbench
=============================

Name: prco_fetch

Overview:
Instruction fetch unit for the PRCO core; it answers the decoder's fetch handshake. It owns the program counter and reads 16-bit words from a synchronous instruction ROM. It presents each word on q_instr with a one-cycle q_ce strobe, which drives the decoder's i_ce. It also accepts jump redirects from the execute stage.

Parameters:
PC_WIDTH, 8, width of program counter and ROM word address.
RESET_PC, 0, PC value loaded at reset.
MEM_LATENCY, 1, ROM read latency in clocks; legal range 1..4.

Ports:
i_clk  input  1  core clock; all state on rising edge.
i_reset  input  1  asynchronous, active-low reset (0 = reset).
i_en  input  1  fetch enable; when 0, no new fetch starts.
i_fetch  input  1  one-cycle request for the next instruction (decoder q_fetch).
i_jmp  input  1  one-cycle redirect strobe.
i_jmp_addr  input  PC_WIDTH  redirect target, valid with i_jmp.
q_mem_addr  output  PC_WIDTH  ROM word address.
q_mem_re  output  1  ROM read strobe.
i_mem_data  input  16  ROM read data, valid MEM_LATENCY clocks after the edge that sampled q_mem_re.
q_instr  output  16  fetched instruction (decoder i_instr).
q_ce  output  1  one-cycle "instruction valid" strobe (decoder i_ce).
q_pc  output  PC_WIDTH  address of the next word to fetch.
q_busy  output  1  high while a ROM read is in flight.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=BOOT, q_pc=RESET_PC, q_mem_addr=0, q_mem_re=0, q_instr=16'h0000, q_ce=0, q_busy=0, pending=0, flush=0.
  - The reset value of q_instr is the NOP encoding.
- All outputs are registered.
- Flush is an internal flag.
- States:
  - BOOT: at the first edge with i_reset=1 and i_en=1, issue a fetch at q_pc and go to WAIT. There is no i_fetch request for the first instruction.
  - IDLE: at an edge with i_en=1 and (i_fetch or pending), issue a fetch and clear pending.
  - WAIT: count MEM_LATENCY clocks from the issue edge, then capture.
- Issue at edge k:
  - q_mem_addr<=target, where target is i_jmp_addr if i_jmp=1 in that same cycle, otherwise q_pc.
  - q_mem_re<=1 for exactly one cycle; q_busy<=1.
  - q_pc<=target+1, modulo 2^PC_WIDTH (255 wraps to 0).
- Capture at edge k+1+MEM_LATENCY, when flush=0:
  - q_instr<=i_mem_data, q_ce<=1 for exactly one cycle, q_busy<=0.
  - Return to IDLE.
- Latency: an i_fetch sampled at edge k gives q_ce high after edge k+1+MEM_LATENCY (2 clocks for the default).
- i_jmp in IDLE without i_fetch: q_pc<=i_jmp_addr; no fetch starts.
- i_jmp in WAIT:
  - q_pc<=i_jmp_addr and flush<=1.
  - The in-flight read completes, but its data is discarded: no q_ce, q_instr unchanged.
  - One edge later, a fetch at the new q_pc is issued automatically.
  - Any pending request is cleared.
- i_fetch while busy: pending<=1 (one deep; further requests are absorbed). It is served on the edge after capture.
- i_jmp and i_fetch in the same IDLE cycle: the jump wins the address, and a single fetch is issued at i_jmp_addr.
- i_en=0:
  - An in-flight read completes and strobes normally.
  - i_fetch is latched into pending but not issued until i_en=1.
  - i_jmp still updates q_pc.
- Reset mid-WAIT: state is cleared immediately and no q_ce is produced for the aborted read.
- q_ce and q_mem_re are never high for two consecutive cycles.

Test Plan:
1. Boot: RESET_PC=0, ROM[0]=16'h0800; release reset with i_en=1 -> q_mem_addr=0, q_mem_re pulses once, q_ce high 2 clocks later with q_instr=16'h0800, q_pc=1.
2. Sequential and wrap: q_pc=8'hFF, ROM[255]=16'h1234, pulse i_fetch -> q_instr=16'h1234, q_pc=0; a second i_fetch -> q_mem_addr=0.
3. Jump with fetch: in IDLE, i_jmp=1, i_jmp_addr=8'h40, i_fetch=1 in the same cycle -> single read at 8'h40, q_pc=8'h41, one q_ce.
4. Jump in flight: i_fetch at address 5, then i_jmp to 8'h20 during WAIT -> no q_ce for ROM[5]; automatic read at 8'h20 with one q_ce carrying ROM[32].
5. Pending request with latency: MEM_LATENCY=3; i_fetch twice, the second during WAIT -> two strobes with ROM[n] then ROM[n+1], each 4 clocks after its issue edge; no back-to-back q_ce.
6. Reset mid-read: assert i_reset=0 during WAIT -> all outputs take reset values asynchronously, no q_ce follows, and the boot fetch re-runs from RESET_PC after release.

Source files
------------

// File: rtl/prco_fetch.sv
// PRCO instruction fetch unit: owns the program counter, issues reads to a
// synchronous instruction ROM and hands each returned word to the decoder.
module prco_fetch #(
    parameter int unsigned         PC_WIDTH    = 32'd8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
    parameter int unsigned         MEM_LATENCY = 32'd1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic                i_fetch,
    input  logic                i_jmp,
    input  logic [PC_WIDTH-1:0] i_jmp_addr,
    output logic [PC_WIDTH-1:0] q_mem_addr,
    output logic                q_mem_re,
    input  logic [15:0]         i_mem_data,
    output logic [15:0]         q_instr,
    output logic                q_ce,
    output logic [PC_WIDTH-1:0] q_pc,
    output logic                q_busy
);

    localparam logic [2:0]          LAT_C  = 3'(MEM_LATENCY);
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]         NOP_C  = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r,    state_s;
    logic [PC_WIDTH-1:0] pc_r,       pc_s;
    logic [PC_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic                mem_re_r,   mem_re_s;
    logic [15:0]         instr_r,    instr_s;
    logic                ce_r,       ce_s;
    logic                busy_r,     busy_s;
    logic                pending_r,  pending_s;
    logic                flush_r,    flush_s;
    logic [2:0]          cnt_r,      cnt_s;
    logic [PC_WIDTH-1:0] target_s;

    // Next-state and next-output values of the fetch sequencer.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        mem_addr_s = mem_addr_r;
        mem_re_s   = 1'b0;
        instr_s    = instr_r;
        ce_s       = 1'b0;
        busy_s     = busy_r;
        pending_s  = pending_r;
        flush_s    = flush_r;
        cnt_s      = cnt_r;
        // A redirect in the same cycle always wins the address.
        target_s   = i_jmp ? i_jmp_addr : pc_r;
        case (state_r)
            ST_BOOT, ST_IDLE: begin
                if (i_en && ((state_r == ST_BOOT) || i_fetch || pending_r)) begin
                    state_s    = ST_WAIT;
                    mem_addr_s = target_s;
                    mem_re_s   = 1'b1;
                    busy_s     = 1'b1;
                    pc_s       = target_s + PC_ONE;
                    pending_s  = 1'b0;
                    cnt_s      = 3'd0;
                end else begin
                    pc_s      = target_s;
                    pending_s = pending_r | i_fetch;
                end
            end
            ST_WAIT: begin
                pc_s      = target_s;
                flush_s   = flush_r | i_jmp;
                pending_s = i_jmp ? 1'b0 : (pending_r | i_fetch);
                if (cnt_r == LAT_C) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    flush_s = 1'b0;
                    cnt_s   = 3'd0;
                    // A redirected read is dropped and the new target is fetched next edge.
                    if (flush_r || i_jmp) begin
                        pending_s = 1'b1;
                    end else begin
                        instr_s = i_mem_data;
                        ce_s    = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                busy_s    = 1'b0;
                flush_s   = 1'b0;
                pending_s = 1'b0;
                cnt_s     = 3'd0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            mem_addr_r <= {PC_WIDTH{1'b0}};
            mem_re_r   <= 1'b0;
            instr_r    <= NOP_C;
            ce_r       <= 1'b0;
            busy_r     <= 1'b0;
            pending_r  <= 1'b0;
            flush_r    <= 1'b0;
            cnt_r      <= 3'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            mem_addr_r <= mem_addr_s;
            mem_re_r   <= mem_re_s;
            instr_r    <= instr_s;
            ce_r       <= ce_s;
            busy_r     <= busy_s;
            pending_r  <= pending_s;
            flush_r    <= flush_s;
            cnt_r      <= cnt_s;
        end
    end

    assign q_mem_addr = mem_addr_r;
    assign q_mem_re   = mem_re_r;
    assign q_instr    = instr_r;
    assign q_ce       = ce_r;
    assign q_pc       = pc_r;
    assign q_busy     = busy_r;

endmodule

// File: tb/tb_prco_fetch.sv
// Testbench for prco_fetch: two instances (ROM latency 1 and 3) share one
// stimulus stream; each has a transaction-level model and a scoreboard.
module tb_prco_fetch;

    localparam int PW = 8;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [PW-1:0] addr;
    } exp_t;

    logic          i_clk      = 1'b0;
    logic          i_reset    = 1'b1;
    logic          i_en       = 1'b0;
    logic          i_fetch    = 1'b0;
    logic          i_jmp      = 1'b0;
    logic [PW-1:0] i_jmp_addr = 8'h00;
    logic [PW-1:0] r_addr;
    logic [15:0]   rom [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int lat, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s (MEM_LATENCY=%0d): got %0h, expected %0h at %0t", name, lat, got, want, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : 3;

        logic [PW-1:0] q_mem_addr, q_pc;
        logic          q_mem_re, q_ce, q_busy;
        logic [15:0]   q_instr, mem_data;
        logic [15:0]   pipe [0:3];

        exp_t          rd_q[$];
        exp_t          ce_q[$];
        exp_t          m_e;
        bit            m_due;
        int            m_cyc = 0;
        int            m_issue = 0;
        logic [PW-1:0] m_pc = 8'h00;
        logic [PW-1:0] m_addr = 8'h00;
        logic [PW-1:0] m_tgt;
        bit            m_booted = 1'b0;
        bit            m_inflight = 1'b0;
        bit            m_flush = 1'b0;
        bit            m_pending = 1'b0;

        prco_fetch #(
            .PC_WIDTH   (PW),
            .RESET_PC   (8'h00),
            .MEM_LATENCY(L)
        ) dut (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_en       (i_en),
            .i_fetch    (i_fetch),
            .i_jmp      (i_jmp),
            .i_jmp_addr (i_jmp_addr),
            .q_mem_addr (q_mem_addr),
            .q_mem_re   (q_mem_re),
            .i_mem_data (mem_data),
            .q_instr    (q_instr),
            .q_ce       (q_ce),
            .q_pc       (q_pc),
            .q_busy     (q_busy)
        );

        // ROM: data is valid only in the cycle it is due, poison otherwise.
        assign mem_data = pipe[L-1];
        always @(posedge i_clk) begin
            pipe[0] <= q_mem_re ? rom[q_mem_addr] : 16'hDEAD;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        // Reference model: one transaction at a time, capture at issue+1+L.
        always @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                m_booted = 1'b0; m_inflight = 1'b0; m_flush = 1'b0; m_pending = 1'b0;
                m_pc = 8'h00;
                rd_q.delete();
                ce_q.delete();
            end else begin
                m_cyc++;
                m_tgt = i_jmp ? i_jmp_addr : m_pc;
                if (m_inflight) begin
                    if (i_jmp) begin
                        m_flush = 1'b1; m_pending = 1'b0; m_pc = i_jmp_addr;
                    end else if (i_fetch) begin
                        m_pending = 1'b1;
                    end
                    if (m_cyc == m_issue + 1 + L) begin
                        m_inflight = 1'b0;
                        if (m_flush) begin
                            m_flush = 1'b0; m_pending = 1'b1;
                        end else begin
                            ce_q.push_back('{m_cyc, rom[m_addr], m_pc});
                        end
                    end
                end else if (i_en && (!m_booted || i_fetch || m_pending)) begin
                    m_booted = 1'b1; m_inflight = 1'b1; m_pending = 1'b0;
                    m_issue = m_cyc; m_addr = m_tgt; m_pc = m_tgt + 8'd1;
                    rd_q.push_back('{m_cyc, 16'h0000, m_tgt});
                end else begin
                    if (i_jmp) m_pc = i_jmp_addr;
                    if (i_fetch) m_pending = 1'b1;
                end
            end
        end

        // Monitor: pop and compare whenever a strobe appears or one is due.
        always @(negedge i_clk) begin
            if (i_reset) begin
                m_due = (rd_q.size() > 0) && (rd_q[0].cyc == m_cyc);
                if (q_mem_re || m_due) begin
                    chk("mem_re", L, q_mem_re, m_due);
                    if (m_due) begin
                        m_e = rd_q.pop_front();
                        if (q_mem_re) chk("mem_addr", L, q_mem_addr, m_e.addr);
                    end
                end
                m_due = (ce_q.size() > 0) && (ce_q[0].cyc == m_cyc);
                if (q_ce || m_due) begin
                    chk("ce", L, q_ce, m_due);
                    if (m_due) begin
                        m_e = ce_q.pop_front();
                        if (q_ce) begin
                            chk("instr", L, q_instr, m_e.data);
                            chk("pc_at_ce", L, q_pc, m_e.addr);
                        end
                    end
                end
                chk("pc", L, q_pc, m_pc);
                chk("busy", L, q_busy, m_inflight);
            end
        end

        // Outputs must take reset values immediately on reset assertion.
        always @(negedge i_reset) begin
            #1;
            chk("rst_pc", L, q_pc, 8'h00);
            chk("rst_mem_addr", L, q_mem_addr, 8'h00);
            chk("rst_mem_re", L, q_mem_re, 1'b0);
            chk("rst_instr", L, q_instr, 16'h0000);
            chk("rst_ce", L, q_ce, 1'b0);
            chk("rst_busy", L, q_busy, 1'b0);
        end
    end

    task automatic step(input logic en, input logic fetch, input logic jmp, input logic [PW-1:0] addr);
        i_en = en; i_fetch = fetch; i_jmp = jmp; i_jmp_addr = addr;
        @(posedge i_clk);
        #2;
        i_fetch = 1'b0; i_jmp = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0]   = 16'h0800;
        rom[255] = 16'h1234;
        #1 i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 i_en = 1'b1; i_reset = 1'b1;
        idle(8);                                    // boot fetch of ROM[0]
        step(1'b1, 1'b0, 1'b1, 8'hFF);              // pc to 255
        step(1'b1, 1'b1, 1'b0, 8'h00); idle(8);     // fetch ROM[255], pc wraps
        step(1'b1, 1'b1, 1'b0, 8'h00); idle(8);     // fetch at 0
        step(1'b1, 1'b1, 1'b1, 8'h40); idle(8);     // jump + fetch same cycle
        step(1'b1, 1'b0, 1'b1, 8'h05);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h20); idle(10);    // jump while in flight
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00); idle(12);    // pending request
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        idle(10);                                   // pending served after enable
        step(1'b1, 1'b1, 1'b0, 8'h00);
        #1 i_reset = 1'b0;                          // reset mid-read
        repeat (2) @(posedge i_clk);
        #2 i_reset = 1'b1;
        idle(10);
        for (int c = 0; c < 3000; c++) begin
            r_addr = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0), r_addr);
        end
        idle(12);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
